ram_wb_slave: RTL and testbench

Wishbone B3 classic/registered-burst slave that sits directly upstream of the on-chip single-port RAM. It decodes the bus address, drives the RAM's synchronous port (word address, byte enables, write data, write enable) and returns read data from the RAM's one-cycle registered output. It generates `ack`/`err` and supports linear incrementing bursts at one beat per cycle after a single initial wait cycle.

---
 rtl/ram_wb_slave.sv | 140 ++++++++++++++
 tb/tb_ram_wb_slave.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_wb_slave.sv
// ram_wb_slave: Wishbone B3 classic / incrementing-burst slave in front of a
// single-port synchronous RAM with a one-cycle registered read port.
// Latency: one wait cycle on the first beat, then one ack per cycle in bursts.
// Backpressure: master stalls by dropping wb_stb_i; the slave holds its beat
// address and re-reads the pending word so data is valid when stb returns.
//
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   wb_cyc_i .. wb_cti_i   Wishbone slave request side (byte address in)
//   wb_dat_o, wb_ack_o,
//   wb_err_o               Wishbone response side
//   ram_we_o, ram_adr_o,
//   ram_be_o, ram_dat_o    RAM write/address port (word addressed)
//   ram_dat_i              RAM registered read data
module ram_wb_slave #(
  parameter int          ADDR_W    = 12,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [31:0]       wb_adr_i,
  input  logic [3:0]        wb_sel_i,
  input  logic [31:0]       wb_dat_i,
  input  logic [2:0]        wb_cti_i,
  output logic [31:0]       wb_dat_o,
  output logic              wb_ack_o,
  output logic              wb_err_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_adr_o,
  output logic [3:0]        ram_be_o,
  output logic [31:0]       ram_dat_o,
  input  logic [31:0]       ram_dat_i
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  localparam logic [2:0] CTI_INCR = 3'b010;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cur_q, cur_d;

  logic              req;
  logic              hit;
  logic [ADDR_W-1:0] adr_word;
  logic [ADDR_W-1:0] cur_inc;

  assign req      = wb_cyc_i & wb_stb_i;
  assign hit      = (wb_adr_i[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]) &&
                    (wb_adr_i[1:0] == 2'b00);
  assign adr_word = wb_adr_i[ADDR_W+1:2];
  // Natural wrap of the ADDR_W-bit add keeps bursts inside the RAM.
  assign cur_inc  = cur_q + ADDR_W'(1);

  assign ram_be_o  = wb_sel_i;
  assign ram_dat_o = wb_dat_i;

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    wb_ack_o  = 1'b0;
    wb_err_o  = 1'b0;
    ram_we_o  = 1'b0;
    ram_adr_o = cur_q;
    wb_dat_o  = '0;

    case (state_q)
      ST_IDLE: begin
        // Present the incoming address straight to the RAM so the read
        // data is ready in the following (ack) cycle.
        ram_adr_o = adr_word;
        if (req) begin
          if (hit) begin
            state_d = ST_XFER;
            cur_d   = adr_word;
          end else begin
            state_d = ST_ERR;
          end
        end
      end

      ST_XFER: begin
        if (req) begin
          wb_ack_o = 1'b1;
          ram_we_o = wb_we_i;
          if (wb_cti_i == CTI_INCR) begin
            cur_d = cur_inc;
            // Prefetch the next word so the next beat can ack immediately.
            if (!wb_we_i) begin
              ram_adr_o = cur_inc;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_ERR: begin
        wb_err_o = req;
        state_d  = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (!wb_cyc_i) begin
      state_d = ST_IDLE;
    end

    // Reset suppresses every response and any RAM write in the same cycle.
    if (rst_i) begin
      wb_ack_o = 1'b0;
      wb_err_o = 1'b0;
      ram_we_o = 1'b0;
    end

    if (wb_ack_o && !wb_we_i) begin
      wb_dat_o = ram_dat_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cur_q   <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
    end
  end

endmodule

// File: tb/tb_ram_wb_slave.sv
// tb_ram_wb_slave: directed plus randomized checks of ram_wb_slave against a
// word-array reference memory and the cycle timing of single/burst/error
// transfers. The bench also models the synchronous RAM behind the slave.
module tb_ram_wb_slave;

  localparam int          AW   = 12;
  localparam int          NW   = 1 << AW;
  localparam logic [31:0] BASE = 32'h8000_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic          cyc, stb, we;
  logic [31:0]   adr;
  logic [3:0]    sel;
  logic [31:0]   dat;
  logic [2:0]    cti;
  logic [31:0]   dat_o;
  logic          ack, err;
  logic          ram_we;
  logic [AW-1:0] ram_adr;
  logic [3:0]    ram_be;
  logic [31:0]   ram_wdat;
  logic [31:0]   ram_rdat;
  logic          bd_init;

  logic [31:0] ram     [0:NW-1];
  logic [31:0] ref_mem [0:NW-1];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ram_wb_slave #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .wb_cyc_i  (cyc),
    .wb_stb_i  (stb),
    .wb_we_i   (we),
    .wb_adr_i  (adr),
    .wb_sel_i  (sel),
    .wb_dat_i  (dat),
    .wb_cti_i  (cti),
    .wb_dat_o  (dat_o),
    .wb_ack_o  (ack),
    .wb_err_o  (err),
    .ram_we_o  (ram_we),
    .ram_adr_o (ram_adr),
    .ram_be_o  (ram_be),
    .ram_dat_o (ram_wdat),
    .ram_dat_i (ram_rdat)
  );

  function automatic logic [31:0] pat(input int i);
    logic [31:0] v;
    v = 32'(i);
    return (v * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  // Synchronous single-port RAM, read-before-write, one-cycle read latency.
  always @(posedge clk) begin
    if (bd_init) begin
      for (int i = 0; i < NW; i++) ram[i] <= pat(i);
    end else if (ram_we) begin
      for (int b = 0; b < 4; b++)
        if (ram_be[b]) ram[ram_adr][8*b +: 8] <= ram_wdat[8*b +: 8];
    end
    ram_rdat <= ram[ram_adr];
  end

  function automatic int wrap(input int w);
    return ((w % NW) + NW) % NW;
  endfunction

  function automatic logic [31:0] addr_of(input int w);
    logic [31:0] ww;
    ww = 32'(wrap(w));
    return BASE | (ww << 2);
  endfunction

  function automatic logic [2:0] rand_end();
    logic [2:0] c;
    c = 3'($urandom);
    if (c == 3'b010) c = 3'b111;
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic bus_idle();
    cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0;
    sel = '0;   dat = '0;   cti = 3'b000;
  endtask

  task automatic ref_write(input int wd, input logic [3:0] s, input logic [31:0] d);
    for (int b = 0; b < 4; b++)
      if (s[b]) ref_mem[wd][8*b +: 8] = d[8*b +: 8];
  endtask

  // Single classic access; starts right after a clock edge.
  task automatic single(input logic w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, input logic [2:0] c,
                        output logic [31:0] rd);
    int wd;
    wd = int'(a[AW+1:2]);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat = d; cti = c;
    samp();
    chk("single_wait_ack", 32'(ack), 0);
    chk("single_wait_we", 32'(ram_we), 0);
    step(); samp();
    chk("single_ack", 32'(ack), 1);
    chk("single_noerr", 32'(err), 0);
    rd = dat_o;
    if (w) begin
      chk("single_ram_we", 32'(ram_we), 1);
      chk("single_ram_adr", 32'(ram_adr), 32'(wd));
      chk("single_ram_be", 32'(ram_be), 32'(s));
      chk("single_ram_dat", ram_wdat, d);
    end else begin
      chk("single_ram_we_rd", 32'(ram_we), 0);
      chk("single_rdata", dat_o, ref_mem[wd]);
    end
    step();
    if (w) ref_write(wd, s, d);
    bus_idle();
    samp();
    chk("single_after_ack", 32'(ack), 0);
    chk("single_after_dat", dat_o, 0);
    step();
  endtask

  task automatic set_beat(input int w0, input int i, input int n, input logic [2:0] last_cti,
                          output logic [31:0] d, output logic [3:0] s);
    d = $urandom;
    s = 4'($urandom);
    adr = addr_of(w0 + i);
    cti = (i == n - 1) ? last_cti : 3'b010;
    dat = d;
    sel = s;
  endtask

  // Incrementing burst of n beats; optional fixed stall after one beat plus
  // random stalls up to max_stall cycles between beats.
  task automatic burst(input logic w, input int w0, input int n, input int max_stall,
                       input int stall_after, input int stall_len, input logic [2:0] last_cti);
    logic [31:0] d;
    logic [3:0]  s;
    int          wd, stall;
    cyc = 1'b1; stb = 1'b1; we = w;
    set_beat(w0, 0, n, last_cti, d, s);
    samp();
    chk("burst_wait_ack", 32'(ack), 0);
    step();
    for (int i = 0; i < n; i++) begin
      wd = wrap(w0 + i);
      samp();
      chk("burst_ack", 32'(ack), 1);
      chk("burst_noerr", 32'(err), 0);
      if (w) begin
        chk("burst_ram_we", 32'(ram_we), 1);
        chk("burst_ram_adr", 32'(ram_adr), 32'(wd));
      end else begin
        chk("burst_ram_we_rd", 32'(ram_we), 0);
        chk("burst_rdata", dat_o, ref_mem[wd]);
      end
      step();
      if (w) ref_write(wd, s, d);
      if (i < n - 1) begin
        stall = (i == stall_after) ? stall_len :
                (max_stall > 0 ? int'($urandom_range(0, max_stall)) : 0);
        for (int k = 0; k < stall; k++) begin
          stb = 1'b0;
          samp();
          chk("stall_noack", 32'(ack), 0);
          chk("stall_nowe", 32'(ram_we), 0);
          step();
        end
        stb = 1'b1;
        set_beat(w0, i + 1, n, last_cti, d, s);
      end
    end
    bus_idle();
    samp();
    chk("burst_done_noack", 32'(ack), 0);
    step();
  endtask

  task automatic bad(input logic [31:0] a, input logic w);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = 4'hF; dat = $urandom; cti = 3'b000;
    samp();
    chk("bad_wait_err", 32'(err), 0);
    chk("bad_wait_ack", 32'(ack), 0);
    step(); samp();
    chk("bad_err", 32'(err), 1);
    chk("bad_noack", 32'(ack), 0);
    chk("bad_nowe", 32'(ram_we), 0);
    step();
    bus_idle();
    samp();
    chk("bad_err_once", 32'(err), 0);
    step();
  endtask

  initial begin
    logic [31:0] rd, a;
    logic [31:0] d0;
    int          mism;

    bus_idle();
    rst = 1'b1;
    bd_init = 1'b1;
    for (int i = 0; i < NW; i++) ref_mem[i] = pat(i);
    step();
    bd_init = 1'b0;

    // Responses stay quiet while reset is held, even with a valid request.
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = addr_of(8); sel = 4'hF; dat = 32'h1234_5678;
    samp();
    chk("rst_ack", 32'(ack), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_we", 32'(ram_we), 0);
    chk("rst_dat", dat_o, 0);
    step(); samp();
    chk("rst_ack2", 32'(ack), 0);
    chk("rst_we2", 32'(ram_we), 0);
    step();
    bus_idle();
    rst = 1'b0;
    adr = addr_of(77);
    samp();
    chk("idle_addr_mux", 32'(ram_adr), 77);
    step();

    // Full-word write, readback, then a single-lane update.
    single(1'b1, 32'h8000_0010, 4'b1111, 32'hDEAD_BEEF, 3'b000, rd);
    single(1'b0, 32'h8000_0010, 4'b1111, 32'h0, 3'b000, rd);
    chk("tp_read_deadbeef", rd, 32'hDEAD_BEEF);
    single(1'b1, 32'h8000_0010, 4'b0010, 32'h0000_AB00, 3'b000, rd);
    single(1'b0, 32'h8000_0010, 4'b1111, 32'h0, 3'b111, rd);
    chk("tp_read_byte", rd, 32'hDEAD_ABEF);

    // Four-beat read bursts from known words, plain and stalled after beat 1.
    single(1'b1, addr_of(0), 4'hF, 32'h3c1d_8000, 3'b000, rd);
    single(1'b1, addr_of(1), 4'hF, 32'h27bd_13e0, 3'b000, rd);
    single(1'b1, addr_of(2), 4'hF, 32'h3c19_8000, 3'b000, rd);
    single(1'b1, addr_of(3), 4'hF, 32'h2739_0210, 3'b000, rd);
    burst(1'b0, 0, 4, 0, -1, 0, 3'b111);
    burst(1'b0, 0, 4, 0, 0, 2, 3'b111);

    // Bursts that wrap from the last word to word 0.
    burst(1'b0, NW - 2, 4, 0, -1, 0, 3'b111);
    burst(1'b1, NW - 2, 3, 1, -1, 0, 3'b000);
    burst(1'b0, NW - 3, 5, 2, -1, 0, 3'b111);

    // Misaligned and out-of-window accesses.
    bad(32'h8000_0002, 1'b1);
    bad(32'h8000_4000, 1'b0);
    bad(32'h8000_4000, 1'b1);

    // Reset during beat 2 of a write burst: only beat 1 reaches the RAM.
    cyc = 1'b1; stb = 1'b1; we = 1'b1;
    adr = addr_of(100); cti = 3'b010; sel = 4'hF; d0 = $urandom; dat = d0;
    samp();
    chk("rstb_wait", 32'(ack), 0);
    step(); samp();
    chk("rstb_ack1", 32'(ack), 1);
    chk("rstb_we1", 32'(ram_we), 1);
    step();
    ref_write(100, 4'hF, d0);
    adr = addr_of(101); dat = $urandom;
    rst = 1'b1;
    samp();
    chk("rstb_ack2", 32'(ack), 0);
    chk("rstb_we2", 32'(ram_we), 0);
    chk("rstb_err2", 32'(err), 0);
    chk("rstb_dat2", dat_o, 0);
    step();
    rst = 1'b0;
    samp();
    chk("rstb_idle_ack", 32'(ack), 0);
    chk("rstb_idle_we", 32'(ram_we), 0);
    step();
    bus_idle();
    samp();
    chk("rstb_drop_we", 32'(ram_we), 0);
    step();
    for (int i = 0; i < 4; i++) single(1'b0, addr_of(100 + i), 4'hF, 32'h0, 3'b000, rd);

    // Randomized mix of accesses against the reference memory.
    for (int it = 0; it < 150; it++) begin
      case ($urandom_range(0, 3))
        0: single(1'b1, addr_of(int'($urandom_range(0, NW - 1))), 4'($urandom),
                  $urandom, rand_end(), rd);
        1: single(1'b0, addr_of(int'($urandom_range(0, NW - 1))), 4'hF,
                  32'h0, rand_end(), rd);
        2: burst(1'($urandom), int'($urandom_range(0, NW - 1)),
                 int'($urandom_range(1, 6)), 2, -1, 0, rand_end());
        default: begin
          if ($urandom_range(0, 1) == 0) begin
            a = addr_of(int'($urandom_range(0, NW - 1))) | 32'($urandom_range(1, 3));
          end else begin
            a = $urandom;
            if (a[31:AW+2] == BASE[31:AW+2]) a[31] = ~a[31];
          end
          bad(a, 1'($urandom));
        end
      endcase
    end

    mism = 0;
    for (int i = 0; i < NW; i++) if (ram[i] !== ref_mem[i]) mism++;
    chk("final_mem_mismatches", 32'(mism), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
